// File: rtl/sopc_data_bus_pkg.sv
// Shared types and constants for the SOPC data-bus bridge.
// Holds the FSM encoding, error read-data value and error-counter limits.
package sopc_data_bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_ACCESS = 2'd1,
        BUS_RESP   = 2'd2
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'h0;
    localparam int          ERR_CNT_W    = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/sopc_data_bus_addr_decoder.sv
// Combinational address decoder: one-hot slave hit vector plus a miss flag.
// Overlapping regions resolve to the lowest slave index.
module sopc_addr_decoder
    import sopc_data_bus_pkg::*;
#(
    parameter int                    NUM_SLV  = 2,
    parameter int                    AW       = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_0000}
) (
    input  logic [AW-1:0]      addr_i,
    output logic [NUM_SLV-1:0] hit_o,
    output logic               miss_o
);

    logic found;

    always_comb begin
        hit_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!found && ((addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hit_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign miss_o = ~found;

endmodule

// File: rtl/sopc_data_bus.sv
// Single-master, N-slave data-bus bridge with address decode, ready handshake,
// access timeout, bus-error reporting and a saturating error counter.
module sopc_data_bus
    import sopc_data_bus_pkg::*;
#(
    parameter int                    NUM_SLV  = 2,
    parameter int                    AW       = 32,
    parameter int                    DW       = 32,
    parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter int                    TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_ce,
    input  logic                  m_we,
    input  logic [AW-1:0]         m_addr,
    input  logic [DW/8-1:0]       m_sel,
    input  logic [DW-1:0]         m_wdata,
    output logic [DW-1:0]         m_rdata,
    output logic                  m_ready,
    output logic                  m_err,
    output logic [15:0]           err_cnt,
    output logic [NUM_SLV-1:0]    s_ce,
    output logic                  s_we,
    output logic [AW-1:0]         s_addr,
    output logic [DW/8-1:0]       s_sel,
    output logic [DW-1:0]         s_wdata,
    input  logic [NUM_SLV*DW-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]    s_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    bus_state_t             state_q, state_d;
    logic [NUM_SLV-1:0]     s_ce_q, s_ce_d;
    logic                   s_we_q, s_we_d;
    logic [AW-1:0]          s_addr_q, s_addr_d;
    logic [DW/8-1:0]        s_sel_q, s_sel_d;
    logic [DW-1:0]          s_wdata_q, s_wdata_d;
    logic [DW-1:0]          m_rdata_q, m_rdata_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [NUM_SLV-1:0]     hit;
    logic                   miss;
    logic                   sel_ack;
    logic                   timeout_hit;
    logic [DW-1:0]          sel_rdata;

    sopc_addr_decoder #(
        .NUM_SLV  (NUM_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr_i (m_addr),
        .hit_o  (hit),
        .miss_o (miss)
    );

    // Only the slave currently enabled may complete the access.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s_ce_q[i]) sel_rdata = s_rdata[i*DW +: DW];
        end
    end

    assign sel_ack     = |(s_ack & s_ce_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        s_ce_d    = s_ce_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_sel_d   = s_sel_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            BUS_IDLE: begin
                if (m_ce) begin
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_sel_d   = m_sel;
                    s_wdata_d = m_wdata;
                    cnt_d     = '0;
                    if (miss) begin
                        m_rdata_d = DW'(BUS_ERR_DATA);
                        err_d     = 1'b1;
                        state_d   = BUS_RESP;
                    end else begin
                        s_ce_d  = hit;
                        err_d   = 1'b0;
                        state_d = BUS_ACCESS;
                    end
                end
            end
            BUS_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack is checked first so it wins over a simultaneous timeout.
                if (sel_ack) begin
                    m_rdata_d = s_we_q ? DW'(BUS_ERR_DATA) : sel_rdata;
                    err_d     = 1'b0;
                    s_ce_d    = '0;
                    state_d   = BUS_RESP;
                end else if (timeout_hit) begin
                    m_rdata_d = DW'(BUS_ERR_DATA);
                    err_d     = 1'b1;
                    s_ce_d    = '0;
                    state_d   = BUS_RESP;
                end
            end
            BUS_RESP: begin
                if (err_q && (err_cnt_q != ERR_CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
                state_d = BUS_IDLE;
            end
            default: begin
                s_ce_d  = '0;
                state_d = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUS_IDLE;
            s_ce_q    <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_sel_q   <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_ce_q    <= s_ce_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_sel_q   <= s_sel_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_ready = (state_q == BUS_RESP);
    assign m_err   = (state_q == BUS_RESP) && err_q;
    assign m_rdata = m_rdata_q;
    assign err_cnt = err_cnt_q;
    assign s_ce    = s_ce_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_sel   = s_sel_q;
    assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed bench for sopc_data_bus (TIMEOUT=4) plus a standalone overlapping-region decoder.
module tb_sopc_data_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_ce, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_sel;
    logic        m_ready, m_err;
    logic [15:0] err_cnt;
    logic [1:0]  s_ce;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic [63:0] s_rdata;
    logic [1:0]  s_ack;

    logic [31:0] dec_addr;
    logic [1:0]  dec_hit;
    logic        dec_miss;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sopc_data_bus #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .err_cnt(err_cnt),
        .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    sopc_addr_decoder #(
        .NUM_SLV(2), .AW(32),
        .SLV_BASE({32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK({32'hFFFF_0000, 32'hFFFF_F000})
    ) u_dec_ov (
        .addr_i(dec_addr), .hit_o(dec_hit), .miss_o(dec_miss)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd);
        m_ce    = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_sel   = sel;
        m_wdata = wd;
    endtask

    initial begin
        rst = 1'b1; m_ce = 0; m_we = 0; m_addr = 0; m_sel = 0; m_wdata = 0;
        s_rdata = 0; s_ack = 0; dec_addr = 0;
        repeat (2) @(negedge clk);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_m_err",   m_err,   0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_s_ce",    s_ce,    0);
        chk("rst_s_we",    s_we,    0);
        chk("rst_s_addr",  s_addr,  0);
        chk("rst_s_sel",   s_sel,   0);
        chk("rst_s_wdata", s_wdata, 0);
        rst = 1'b0;

        // zero-wait read from slave0
        req(0, 32'h0000_0010, 4'hF, 0);
        s_rdata[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd0_s_ce",    s_ce,    2'b01);
        chk("rd0_s_addr",  s_addr,  32'h10);
        chk("rd0_ready_early", m_ready, 0);
        s_ack = 2'b01;
        @(negedge clk);
        chk("rd0_ready",   m_ready, 1);
        chk("rd0_err",     m_err,   0);
        chk("rd0_rdata",   m_rdata, 32'hDEAD_BEEF);
        chk("rd0_s_ce_off", s_ce,   0);
        m_ce = 0; s_ack = 0;
        @(negedge clk);
        chk("rd0_ready_once", m_ready, 0);
        chk("rd0_rdata_hold", m_rdata, 32'hDEAD_BEEF);

        // timeout on slave0
        req(0, 32'h0000_0020, 4'hF, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_s_ce",  s_ce,    2'b01);
            chk("to_ready", m_ready, 0);
        end
        @(negedge clk);
        chk("to_ready_done", m_ready, 1);
        chk("to_err",        m_err,   1);
        chk("to_rdata",      m_rdata, 0);
        chk("to_s_ce_off",   s_ce,    0);
        chk("to_cnt_before", err_cnt, 0);
        m_ce = 0;
        @(negedge clk);
        chk("to_cnt_after",  err_cnt, 1);

        // ack together with the last timeout count
        req(0, 32'h0000_0024, 4'hF, 0);
        s_rdata[31:0] = 32'h0BAD_CAFE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) s_ack = 2'b01;
        end
        @(negedge clk);
        chk("race_ready", m_ready, 1);
        chk("race_err",   m_err,   0);
        chk("race_rdata", m_rdata, 32'h0BAD_CAFE);
        m_ce = 0; s_ack = 0;
        @(negedge clk);
        chk("race_cnt",   err_cnt, 1);

        // unmapped access
        req(0, 32'h8000_0000, 4'hF, 0);
        @(negedge clk);
        chk("um_ready", m_ready, 1);
        chk("um_err",   m_err,   1);
        chk("um_s_ce",  s_ce,    0);
        chk("um_rdata", m_rdata, 0);
        m_ce = 0;
        @(negedge clk);
        chk("um_cnt",   err_cnt, 2);
        chk("um_ready_once", m_ready, 0);

        // write to slave1 with three wait states and a stray slave0 ack
        req(1, 32'h0001_0004, 4'b0011, 32'h1234_5678);
        s_rdata[63:32] = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wr_s_ce",    s_ce,    2'b10);
            chk("wr_s_we",    s_we,    1);
            chk("wr_s_addr",  s_addr,  32'h0001_0004);
            chk("wr_s_sel",   s_sel,   4'b0011);
            chk("wr_s_wdata", s_wdata, 32'h1234_5678);
            chk("wr_ready",   m_ready, 0);
            s_ack = (k == 1) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
        end
        @(negedge clk);
        chk("wr_ready_done", m_ready, 1);
        chk("wr_err",        m_err,   0);
        chk("wr_rdata",      m_rdata, 0);
        chk("wr_s_ce_off",   s_ce,    0);
        m_ce = 0; s_ack = 0;
        @(negedge clk);
        chk("wr_cnt", err_cnt, 2);

        // reset during the second wait cycle
        req(0, 32'h0001_0008, 4'hF, 0);
        @(negedge clk);
        chk("rm_s_ce", s_ce, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_s_ce_off", s_ce,    0);
        chk("rm_ready",    m_ready, 0);
        chk("rm_cnt",      err_cnt, 0);
        chk("rm_s_addr",   s_addr,  0);
        rst = 1'b0; m_ce = 0;
        @(negedge clk);
        chk("rm_ready_after", m_ready, 0);
        req(0, 32'h0000_0100, 4'hF, 0);
        s_rdata[31:0] = 32'h5A5A_1234;
        @(negedge clk);
        chk("rm_rd_s_ce", s_ce, 2'b01);
        s_ack = 2'b01;
        @(negedge clk);
        chk("rm_rd_ready", m_ready, 1);
        chk("rm_rd_rdata", m_rdata, 32'h5A5A_1234);
        chk("rm_rd_err",   m_err,   0);
        m_ce = 0; s_ack = 0;
        @(negedge clk);

        // error counter saturation
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        chk("sat_preset", err_cnt, 16'hFFFE);
        for (int i = 0; i < 2; i++) begin
            req(0, 32'h8000_0000, 4'hF, 0);
            @(negedge clk);
            chk("sat_err", m_err, 1);
            m_ce = 0;
            @(negedge clk);
            chk("sat_cnt", err_cnt, 16'hFFFF);
        end

        // overlapping regions resolve to lowest index
        dec_addr = 32'h0000_0010; #1;
        chk("ov_both_hit",  dec_hit,  2'b01);
        chk("ov_both_miss", dec_miss, 0);
        dec_addr = 32'h0000_8000; #1;
        chk("ov_s1_hit",    dec_hit,  2'b10);
        dec_addr = 32'h0001_0000; #1;
        chk("ov_none_hit",  dec_hit,  2'b00);
        chk("ov_none_miss", dec_miss, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
